// File: rtl/free_list_reclaim.sv
// free_list_reclaim
//   Return path for a pre-initialised free-list FIFO holding the IDs
//   INIT_VAL .. INIT_VAL+DEPTH-1. Every ID popped from the free list is
//   recorded in an outstanding bitmap. Freed IDs are checked against that
//   bitmap, and legal ones are pushed back toward the free-list FIFO input
//   through a 2-entry buffer.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i__alloc_valid/_id    free-list output handshake fired, with the popped ID
//   i__free_valid/_id     freed ID offered; accepted when valid && o__free_ready
//   o__free_ready         buffer not full (registered)
//   o__ret_valid/_id      ID to push back into the free list
//   i__ret_ready          free-list FIFO input ready
//   o__outstanding        number of IDs currently allocated
//   o__err_bad_id         sticky: alloc or free of an out-of-range ID
//   o__err_double_free    sticky: free of an ID that is not outstanding
//   o__err_double_alloc   sticky: alloc of an ID that is already outstanding
module free_list_reclaim #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 3,
  parameter int INIT_VAL   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i__alloc_valid,
  input  logic [DATA_WIDTH-1:0]        i__alloc_id,
  input  logic                         i__free_valid,
  input  logic [DATA_WIDTH-1:0]        i__free_id,
  output logic                         o__free_ready,
  output logic                         o__ret_valid,
  output logic [DATA_WIDTH-1:0]        o__ret_id,
  input  logic                         i__ret_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o__outstanding,
  output logic                         o__err_bad_id,
  output logic                         o__err_double_free,
  output logic                         o__err_double_alloc
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] BASE   = DATA_WIDTH'(INIT_VAL);
  localparam logic [DATA_WIDTH-1:0] SPAN   = DATA_WIDTH'(DEPTH);

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [DEPTH-1:0]      bitmap;
  logic [DEPTH-1:0]      bitmap_nxt;

  logic [DATA_WIDTH-1:0] alloc_off;
  logic [DATA_WIDTH-1:0] free_off;
  logic [IDX_W-1:0]      alloc_idx;
  logic [IDX_W-1:0]      free_idx;
  logic                  alloc_in_range;
  logic                  free_in_range;
  logic                  free_fire;
  logic                  free_ok;
  logic                  alloc_dup;
  logic                  free_dup;
  logic                  any_bad;

  // Offset from the pool base; a single unsigned compare on the offset
  // covers both ends of the range (IDs below the base wrap to huge values).
  assign alloc_off      = i__alloc_id - BASE;
  assign free_off       = i__free_id - BASE;
  assign alloc_in_range = alloc_off < SPAN;
  assign free_in_range  = free_off < SPAN;
  assign alloc_idx      = alloc_off[IDX_W-1:0];
  assign free_idx       = free_off[IDX_W-1:0];

  assign free_fire = i__free_valid && o__free_ready;
  assign free_ok   = free_fire && free_in_range && bitmap[free_idx];
  assign free_dup  = free_fire && free_in_range && !bitmap[free_idx];
  assign alloc_dup = i__alloc_valid && alloc_in_range && bitmap[alloc_idx];
  assign any_bad   = (i__alloc_valid && !alloc_in_range) ||
                     (free_fire && !free_in_range);

  // Free is applied after alloc so the bitmap and the count stay consistent
  // even if a legal free coincides with a duplicate alloc of the same ID.
  always_comb begin
    bitmap_nxt = bitmap;
    if (i__alloc_valid && alloc_in_range) bitmap_nxt[alloc_idx] = 1'b1;
    if (free_ok)                          bitmap_nxt[free_idx]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap              <= '0;
      o__err_bad_id       <= 1'b0;
      o__err_double_free  <= 1'b0;
      o__err_double_alloc <= 1'b0;
    end else begin
      bitmap <= bitmap_nxt;
      if (any_bad)   o__err_bad_id       <= 1'b1;
      if (free_dup)  o__err_double_free  <= 1'b1;
      if (alloc_dup) o__err_double_alloc <= 1'b1;
    end
  end

  assign o__outstanding = popcount(bitmap);

  // ---- return buffer stage (p1): 2-entry FIFO with registered flags ----
  logic [DATA_WIDTH-1:0] buf_p1 [2];
  logic                  wr_ptr_p1;
  logic                  rd_ptr_p1;
  logic [1:0]            occ_p1;
  logic [1:0]            occ_nxt;
  logic                  pop;

  assign pop     = o__ret_valid && i__ret_ready;
  assign occ_nxt = occ_p1 + 2'(free_ok) - 2'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_p1     <= 1'b0;
      rd_ptr_p1     <= 1'b0;
      occ_p1        <= 2'd0;
      o__ret_valid  <= 1'b0;
      o__free_ready <= 1'b1;
    end else begin
      if (free_ok) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop)     rd_ptr_p1 <= ~rd_ptr_p1;
      occ_p1        <= occ_nxt;
      o__ret_valid  <= occ_nxt != 2'd0;
      o__free_ready <= occ_nxt != 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (free_ok) buf_p1[wr_ptr_p1] <= i__free_id;
  end

  assign o__ret_id = buf_p1[rd_ptr_p1];

endmodule
